// File: rtl/gc_move_engine_if.sv
// Command and flash read/write bundle for the GC page-move engine.
// master: GC controller plus flash model; slave: the move engine.
interface gc_move_engine_if #(
  parameter int BLOCK_W = 10,
  parameter int PAGE_W  = 6,
  parameter int WORD_W  = 32,
  parameter int WIDX_W  = 4
);
  localparam int PAGE_NUM = 1 << PAGE_W;
  localparam int FADDR_W  = BLOCK_W + PAGE_W + WIDX_W;

  logic                mv_req;
  logic [BLOCK_W-1:0]  mv_src_block;
  logic [BLOCK_W-1:0]  mv_dst_block;
  logic [PAGE_NUM-1:0] mv_valid_map;
  logic                gc_abort;
  logic                mv_ack;
  logic                mv_busy;
  logic                mv_done;
  logic                mv_aborted;
  logic [PAGE_W:0]     mv_moved;

  logic                fl_rd_req;
  logic [FADDR_W-1:0]  fl_rd_addr;
  logic                fl_rd_valid;
  logic [WORD_W-1:0]   fl_rd_data;
  logic                fl_wr_req;
  logic [FADDR_W-1:0]  fl_wr_addr;
  logic [WORD_W-1:0]   fl_wr_data;
  logic                fl_wr_ack;

  modport master (
    output mv_req, mv_src_block, mv_dst_block, mv_valid_map, gc_abort,
    input  mv_ack, mv_busy, mv_done, mv_aborted, mv_moved,
    input  fl_rd_req, fl_rd_addr,
    output fl_rd_valid, fl_rd_data,
    input  fl_wr_req, fl_wr_addr, fl_wr_data,
    output fl_wr_ack
  );

  modport slave (
    input  mv_req, mv_src_block, mv_dst_block, mv_valid_map, gc_abort,
    output mv_ack, mv_busy, mv_done, mv_aborted, mv_moved,
    output fl_rd_req, fl_rd_addr,
    input  fl_rd_valid, fl_rd_data,
    output fl_wr_req, fl_wr_addr, fl_wr_data,
    input  fl_wr_ack
  );
endinterface

// File: rtl/gc_move_engine.sv
// GC page-move responder: copies each valid page of a victim block into a
// free block word by word, packing destination pages contiguously from 0.
module gc_move_engine #(
  parameter int BLOCK_W = 10,
  parameter int PAGE_W  = 6,
  parameter int WORD_W  = 32,
  parameter int WIDX_W  = 4
) (
  input logic             CLK,
  input logic             RST,
  gc_move_engine_if.slave bus
);
  localparam int PAGE_NUM = 1 << PAGE_W;

  localparam logic [PAGE_W-1:0] PAGE_ONE  = 1;
  localparam logic [WIDX_W-1:0] WIDX_ONE  = 1;
  localparam logic [PAGE_W:0]   MOVED_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SCAN,
    S_RD,
    S_WR,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [BLOCK_W-1:0]  src_q, src_d;
  logic [BLOCK_W-1:0]  dst_q, dst_d;
  logic [PAGE_NUM-1:0] map_q, map_d;
  logic [PAGE_W-1:0]   page_idx_q, page_idx_d;
  logic [WIDX_W-1:0]   word_idx_q, word_idx_d;
  logic [PAGE_W:0]     moved_q, moved_d;
  logic                abort_q, abort_d;
  logic [WORD_W-1:0]   buf_q, buf_d;
  logic                accept;

  wire last_page = &page_idx_q;
  wire last_word = &word_idx_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      map_q      <= '0;
      page_idx_q <= '0;
      word_idx_q <= '0;
      moved_q    <= '0;
      abort_q    <= 1'b0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      map_q      <= map_d;
      page_idx_q <= page_idx_d;
      word_idx_q <= word_idx_d;
      moved_q    <= moved_d;
      abort_q    <= abort_d;
      buf_q      <= buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    map_d      = map_q;
    page_idx_d = page_idx_q;
    word_idx_d = word_idx_q;
    moved_d    = moved_q;
    buf_d      = buf_q;
    accept     = 1'b0;
    // Abort is sticky for the rest of the command; it only stops at page boundaries.
    abort_d    = abort_q | ((state_q != S_IDLE) & bus.gc_abort);

    unique case (state_q)
      S_IDLE: begin
        if (bus.mv_req) begin
          accept     = 1'b1;
          src_d      = bus.mv_src_block;
          dst_d      = bus.mv_dst_block;
          map_d      = bus.mv_valid_map;
          page_idx_d = '0;
          word_idx_d = '0;
          moved_d    = '0;
          abort_d    = 1'b0;
          state_d    = S_SCAN;
        end
      end
      S_SCAN: begin
        if (abort_q) begin
          state_d = S_DONE;
        end else if (map_q[page_idx_q]) begin
          word_idx_d = '0;
          state_d    = S_RD;
        end else if (last_page) begin
          state_d = S_DONE;
        end else begin
          page_idx_d = page_idx_q + PAGE_ONE;
        end
      end
      S_RD: begin
        if (bus.fl_rd_valid) begin
          buf_d   = bus.fl_rd_data;
          state_d = S_WR;
        end
      end
      S_WR: begin
        if (bus.fl_wr_ack) begin
          if (!last_word) begin
            word_idx_d = word_idx_q + WIDX_ONE;
            state_d    = S_RD;
          end else begin
            moved_d = moved_q + MOVED_ONE;
            if (abort_q || last_page) begin
              state_d = S_DONE;
            end else begin
              page_idx_d = page_idx_q + PAGE_ONE;
              state_d    = S_SCAN;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Destination page equals the moved count: both restart at accept and step together.
  assign bus.mv_ack     = accept;
  assign bus.mv_busy    = (state_q != S_IDLE) | accept;
  assign bus.mv_done    = (state_q == S_DONE);
  assign bus.mv_aborted = (state_q == S_DONE) & abort_q;
  assign bus.mv_moved   = moved_q;

  assign bus.fl_rd_req  = (state_q == S_RD);
  assign bus.fl_rd_addr = {src_q, page_idx_q, word_idx_q};
  assign bus.fl_wr_req  = (state_q == S_WR);
  assign bus.fl_wr_addr = {dst_q, moved_q[PAGE_W-1:0], word_idx_q};
  assign bus.fl_wr_data = buf_q;
endmodule

// File: tb/tb_gc_move_engine.sv
// Bench for gc_move_engine: table of move commands plus random commands,
// checked against a page-list model of the copy, with a reset-mid-move sequence.
module tb_gc_move_engine;
  localparam int BLOCK_W = 10;
  localparam int PAGE_W  = 6;
  localparam int WORD_W  = 32;
  localparam int WIDX_W  = 4;
  localparam int FADDR_W = BLOCK_W + PAGE_W + WIDX_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gc_move_engine_if #(.BLOCK_W(BLOCK_W), .PAGE_W(PAGE_W), .WORD_W(WORD_W), .WIDX_W(WIDX_W)) bus();

  gc_move_engine #(.BLOCK_W(BLOCK_W), .PAGE_W(PAGE_W), .WORD_W(WORD_W), .WIDX_W(WIDX_W)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  typedef struct {
    logic [63:0] map;
    int          src;
    int          dst;
    int          rd_lat;      // -1: random per transfer
    int          wr_lat;
    int          ab_page;     // -1: no abort
    int          ab_word;
    bit          poke;        // wiggle mv_req / mv_src_block while busy
    int          exp_moved;   // -1: model only
    bit          exp_aborted;
    int          exp_cycles;  // ack-to-done distance, -1: unchecked
  } vec_t;

  int checks = 0;
  int failures = 0;
  int model_moved;

  logic [FADDR_W-1:0]        got_rd[$];
  logic [FADDR_W-1:0]        exp_rd[$];
  logic [FADDR_W+WORD_W-1:0] got_wr[$];
  logic [FADDR_W+WORD_W-1:0] exp_wr[$];

  int rd_lat_cfg = 0;
  int wr_lat_cfg = 0;
  int stall_err = 0;
  int overlap_err = 0;

  int rd_cnt = 0, wr_cnt = 0, rd_tgt = 0, wr_tgt = 0;
  logic                p_rd = 1'b0, p_wr = 1'b0;
  logic [FADDR_W-1:0]  p_rd_addr, p_wr_addr;
  logic [WORD_W-1:0]   p_wr_data;

  function automatic logic [WORD_W-1:0] fdata(input logic [FADDR_W-1:0] a);
    return (32'(a) * 32'h9E3779B1) ^ 32'hA5A55A5A;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flash model: answers after a configured number of extra cycles, logs completed transfers.
  initial begin
    bus.fl_rd_valid = 1'b0;
    bus.fl_rd_data  = '0;
    bus.fl_wr_ack   = 1'b0;
    forever begin
      @(negedge clk);
      bus.fl_rd_valid = 1'b0;
      bus.fl_wr_ack   = 1'b0;
      bus.fl_rd_data  = $urandom;
      if (rst) begin
        rd_cnt = 0;
        wr_cnt = 0;
      end else begin
        if (bus.fl_rd_req) begin
          if (rd_cnt == 0) rd_tgt = (rd_lat_cfg < 0) ? int'($urandom_range(0, 4)) : rd_lat_cfg;
          if (rd_cnt >= rd_tgt) begin
            bus.fl_rd_valid = 1'b1;
            bus.fl_rd_data  = fdata(bus.fl_rd_addr);
            got_rd.push_back(bus.fl_rd_addr);
            rd_cnt = 0;
          end else begin
            rd_cnt++;
          end
        end else begin
          rd_cnt = 0;
        end
        if (bus.fl_wr_req) begin
          if (wr_cnt == 0) wr_tgt = (wr_lat_cfg < 0) ? int'($urandom_range(0, 4)) : wr_lat_cfg;
          if (wr_cnt >= wr_tgt) begin
            bus.fl_wr_ack = 1'b1;
            got_wr.push_back({bus.fl_wr_addr, bus.fl_wr_data});
            wr_cnt = 0;
          end else begin
            wr_cnt++;
          end
        end else begin
          wr_cnt = 0;
        end
      end
    end
  end

  // Protocol monitor: request overlap and stability of held requests during stalls.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rst) begin
        p_rd = 1'b0;
        p_wr = 1'b0;
      end else begin
        if (bus.fl_rd_req && bus.fl_wr_req) overlap_err++;
        if (p_rd && !bus.fl_rd_valid && (!bus.fl_rd_req || bus.fl_rd_addr != p_rd_addr)) stall_err++;
        if (p_wr && !bus.fl_wr_ack &&
            (!bus.fl_wr_req || bus.fl_wr_addr != p_wr_addr || bus.fl_wr_data != p_wr_data)) stall_err++;
        p_rd      = bus.fl_rd_req;
        p_rd_addr = bus.fl_rd_addr;
        p_wr      = bus.fl_wr_req;
        p_wr_addr = bus.fl_wr_addr;
        p_wr_data = bus.fl_wr_data;
      end
    end
  end

  // Reference: valid pages in ascending order, packed from destination page 0,
  // stopping after the page that was in flight when abort was raised.
  task automatic build_model(input vec_t v);
    int k = 0;
    exp_rd.delete();
    exp_wr.delete();
    for (int p = 0; p < 64; p++) begin
      if (v.map[p]) begin
        for (int w = 0; w < 16; w++) begin
          logic [FADDR_W-1:0] ra;
          ra = {BLOCK_W'(v.src), PAGE_W'(p), WIDX_W'(w)};
          exp_rd.push_back(ra);
          exp_wr.push_back({BLOCK_W'(v.dst), PAGE_W'(k), WIDX_W'(w), fdata(ra)});
        end
        k++;
        if (p == v.ab_page) break;
      end
    end
    model_moved = k;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int   rb, wb, sb, ob, n, xacks, mism, nrd, nwr;
    logic acked, done, aborted, busy_done, busy_after, done_after, ab_sent;
    logic [PAGE_W:0] moved;
    build_model(v);
    rd_lat_cfg = v.rd_lat;
    wr_lat_cfg = v.wr_lat;
    rb = got_rd.size();
    wb = got_wr.size();
    sb = stall_err;
    ob = overlap_err;
    xacks = 0;
    done = 1'b0;
    ab_sent = 1'b0;
    moved = '0;
    aborted = 1'b0;
    busy_done = 1'b0;

    @(negedge clk);
    bus.mv_src_block = BLOCK_W'(v.src);
    bus.mv_dst_block = BLOCK_W'(v.dst);
    bus.mv_valid_map = v.map;
    bus.mv_req       = 1'b1;
    #1 acked = bus.mv_ack;
    @(negedge clk);
    bus.mv_req = 1'b0;
    n = 1;
    while (!done && n < 30000) begin
      bus.gc_abort = 1'b0;
      if (bus.mv_ack) xacks++;
      if (bus.mv_done) begin
        done      = 1'b1;
        moved     = bus.mv_moved;
        aborted   = bus.mv_aborted;
        busy_done = bus.mv_busy;
      end else begin
        if (v.ab_page >= 0 && !ab_sent && bus.fl_rd_req &&
            bus.fl_rd_addr[WIDX_W +: PAGE_W] == PAGE_W'(v.ab_page) &&
            bus.fl_rd_addr[WIDX_W-1:0] == WIDX_W'(v.ab_word)) begin
          bus.gc_abort = 1'b1;
          ab_sent = 1'b1;
        end
        if (v.poke) begin
          bus.mv_req       = 1'($urandom);
          bus.mv_src_block = BLOCK_W'($urandom);
        end
        @(negedge clk);
        n++;
      end
    end
    bus.mv_req   = 1'b0;
    bus.gc_abort = 1'b0;
    @(negedge clk);
    busy_after = bus.mv_busy;
    done_after = bus.mv_done;

    chk("accept_ack", 64'(acked), 64'd1);
    chk("done_seen", 64'(done), 64'd1);
    chk("extra_ack", 64'(xacks), 64'd0);
    if (v.exp_moved >= 0) chk("moved_table", 64'(moved), 64'(v.exp_moved));
    chk("moved_model", 64'(moved), 64'(model_moved));
    chk("aborted", 64'(aborted), 64'(v.exp_aborted));
    chk("busy_at_done", 64'(busy_done), 64'd1);
    chk("busy_after_done", 64'(busy_after), 64'd0);
    chk("done_one_cycle", 64'(done_after), 64'd0);
    if (v.exp_cycles >= 0) chk("ack_to_done", 64'(n), 64'(v.exp_cycles));

    nrd = got_rd.size() - rb;
    nwr = got_wr.size() - wb;
    chk("rd_count", 64'(nrd), 64'(exp_rd.size()));
    chk("wr_count", 64'(nwr), 64'(exp_wr.size()));
    mism = 0;
    for (int i = 0; i < nrd && i < exp_rd.size(); i++)
      if (got_rd[rb+i] !== exp_rd[i]) mism++;
    chk("rd_addr_seq", 64'(mism), 64'd0);
    mism = 0;
    for (int i = 0; i < nwr && i < exp_wr.size(); i++)
      if (got_wr[wb+i] !== exp_wr[i]) mism++;
    chk("wr_addr_data_seq", 64'(mism), 64'd0);
    chk("stall_stable", 64'(stall_err - sb), 64'd0);
    chk("rd_wr_overlap", 64'(overlap_err - ob), 64'd0);

    $display("cmd %0d: src=%0d dst=%0d map=%h moved=%0d aborted=%0b reads=%0d writes=%0d cycles=%0d",
             idx, v.src, v.dst, v.map, moved, aborted, nrd, nwr, n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test, required completion within time limit");
    $fatal(1);
  end

  initial begin
    vec_t vt[7];
    vec_t rv;
    logic seen;

    vt[0] = '{64'h8000_0000_0000_0021, 3,    7,   0,  0,  -1, 0,  1'b0, 3,  1'b0, -1};
    vt[1] = '{64'h0000_0000_0000_0000, 1,    2,   0,  0,  -1, 0,  1'b0, 0,  1'b0, 65};
    vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 12,   800, 3,  5,  -1, 0,  1'b0, 64, 1'b0, -1};
    vt[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 4,    5,   0,  0,  2,  7,  1'b0, 3,  1'b1, -1};
    vt[4] = '{64'h8000_0000_0000_0001, 1023, 0,   -1, -1, -1, 0,  1'b1, 2,  1'b0, -1};
    vt[5] = '{64'hAAAA_AAAA_AAAA_AAAA, 9,    10,  1,  2,  -1, 0,  1'b0, 32, 1'b0, -1};
    vt[6] = '{64'h0000_0000_0000_0010, 600,  601, 2,  0,  4,  15, 1'b0, 1,  1'b1, -1};

    rst = 1'b1;
    bus.mv_req       = 1'b0;
    bus.mv_src_block = '0;
    bus.mv_dst_block = '0;
    bus.mv_valid_map = '0;
    bus.gc_abort     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", 64'({bus.mv_ack, bus.mv_busy, bus.mv_done, bus.mv_aborted, bus.mv_moved}), 64'd0);
    chk("reset_rd", 64'({bus.fl_rd_req, bus.fl_rd_addr}), 64'd0);
    chk("reset_wr", 64'({bus.fl_wr_req, bus.fl_wr_addr, bus.fl_wr_data}), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vt[i], i);

    // Reset in the middle of a write, then a fresh command must run normally.
    rd_lat_cfg = 2;
    wr_lat_cfg = 1;
    @(negedge clk);
    bus.mv_src_block = 10'd5;
    bus.mv_dst_block = 10'd9;
    bus.mv_valid_map = '1;
    bus.mv_req       = 1'b1;
    @(negedge clk);
    bus.mv_req = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      if (bus.fl_wr_req && bus.mv_moved == 7'd2) seen = 1'b1;
      else @(negedge clk);
    end
    chk("rst_reached_write", 64'(seen), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_ctrl", 64'({bus.mv_ack, bus.mv_busy, bus.mv_done, bus.mv_aborted, bus.mv_moved}), 64'd0);
    chk("async_rst_rd", 64'({bus.fl_rd_req, bus.fl_rd_addr}), 64'd0);
    chk("async_rst_wr", 64'({bus.fl_wr_req, bus.fl_wr_addr, bus.fl_wr_data}), 64'd0);
    $display("reset: asserted during page-2 write, outputs sampled after assertion");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_vec(vt[0], 7);

    for (int i = 0; i < 6; i++) begin
      rv.map         = {$urandom, $urandom} & {$urandom, $urandom};
      rv.src         = int'($urandom_range(0, 1023));
      rv.dst         = int'($urandom_range(0, 1023));
      rv.rd_lat      = -1;
      rv.wr_lat      = -1;
      rv.ab_page     = -1;
      rv.ab_word     = 0;
      rv.poke        = 1'b0;
      rv.exp_moved   = -1;
      rv.exp_aborted = 1'b0;
      rv.exp_cycles  = -1;
      run_vec(rv, 8 + i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
